// File: rtl/muldiv_if.sv
// Multiply/divide request bus: op launch, mthi/mtlo writes, flush, and HI/LO results.
// Master is the pipeline side, slave is the sequencer.
interface muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic                  flush;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, in1, in2, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, in1, in2, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative mult/div sequencer owning HI/LO; DATA_WIDTH+2 cycles start-to-done, start ignored while busy.
// Define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU (done two cycles after start).
module muldiv_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_nx;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    mcand;
    logic [W-1:0]    a_raw;
    logic [CW-1:0]   cnt;
    logic            is_div, sgn, neg_q, neg_r, div0;
    logic [W-1:0]    hi_r, lo_r;

    logic            idle_like, accept, fast;
    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_nx, div_nx, prod;
    logic [W+1:0]    diff;
    logic [W-1:0]    res_hi, res_lo;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = idle_like && bus.start && !bus.flush;

`ifdef MULDIV_FAST_MUL_EN
    logic [W-1:0]    b_raw;
    logic [2*W-1:0]  ext_a, ext_b;
    assign fast  = !bus.op[1];
    assign ext_a = sgn ? {{W{a_raw[W-1]}}, a_raw} : {{W{1'b0}}, a_raw};
    assign ext_b = sgn ? {{W{b_raw[W-1]}}, b_raw} : {{W{1'b0}}, b_raw};
    assign prod  = ext_a * ext_b;
`else
    assign fast  = 1'b0;
    assign prod  = neg_q ? (~acc + 1'b1) : acc;
`endif

    assign a_neg = !bus.op[0] && bus.in1[W-1];
    assign b_neg = !bus.op[0] && bus.in2[W-1];
    assign a_mag = a_neg ? (~bus.in1 + 1'b1) : bus.in1;
    assign b_mag = b_neg ? (~bus.in2 + 1'b1) : bus.in2;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign mul_nx  = {mul_sum, acc[W-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left; restore on borrow.
    assign diff   = {1'b0, acc[2*W-1:W], acc[W-1]} - {2'b00, mcand};
    assign div_nx = diff[W+1] ? {acc[2*W-2:0], 1'b0}
                              : {diff[W-1:0], acc[W-2:0], 1'b1};

    always_comb begin
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (is_div) begin
            if (div0) begin
                res_hi = a_raw;
                res_lo = {W{1'b1}};
            end else begin
                res_hi = neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
                res_lo = neg_q ? (~acc[W-1:0] + 1'b1)   : acc[W-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = fast ? FIX : CALC;
            CALC: if (bus.flush) state_nx = IDLE;
                  else if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = bus.flush ? IDLE : DONE;
            DONE: if (accept) state_nx = fast ? FIX : CALC;
                  else state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            a_raw  <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            sgn    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef MULDIV_FAST_MUL_EN
            b_raw  <= '0;
`endif
        end else begin
            state <= state_nx;
            if (idle_like && bus.hi_we) hi_r <= bus.wdata;
            if (idle_like && bus.lo_we) lo_r <= bus.wdata;
            if (accept) begin
                is_div <= bus.op[1];
                sgn    <= !bus.op[0];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                div0   <= bus.op[1] && (bus.in2 == '0);
                mcand  <= bus.op[1] ? b_mag : a_mag;
                acc    <= {{W{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                a_raw  <= bus.in1;
                cnt    <= CW'(W-1);
`ifdef MULDIV_FAST_MUL_EN
                b_raw  <= bus.in2;
`endif
            end
            if (state == CALC) begin
                acc <= is_div ? div_nx : mul_nx;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
            if ((state == FIX) && !bus.flush) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end
        end
    end

    assign bus.busy = (state == CALC) || (state == FIX);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule
